// File: rtl/braid_dispense_pkg.sv
// Shared types and width helpers for the braid dispense sequencer.
package braid_dispense_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StOn,
        StOff,
        StSettle,
        StDrain,
        StDone
    } state_e;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Phase counter width: one spare bit above the longest phase length.
    function automatic int unsigned phase_width(input int unsigned on_cyc,
                                                input int unsigned off_cyc,
                                                input int unsigned settle_cyc,
                                                input int unsigned drain_cyc);
        return $clog2(max2(max2(on_cyc, off_cyc), max2(settle_cyc, drain_cyc))) + 1;
    endfunction

endpackage

// File: rtl/braid_dispense_seq_dwell_counter.sv
// Loadable down-counter that parks at zero; zero marks the last cycle of a phase.
module dwell_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             zero
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Load on phase entry, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/braid_dispense_seq.sv
// Dispense sequencer for a 16-input mixer braid: pulse-trains one inlet per
// command, then settles, drains and reports completion at the end of a round.
module braid_dispense_seq
    import braid_dispense_pkg::*;
#(
    parameter int unsigned N_IN         = 16,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned VOL_W        = 8,
    parameter int unsigned PULSE_ON     = 2,
    parameter int unsigned PULSE_OFF    = 2,
    parameter int unsigned STAGE_SETTLE = 8,
    parameter int unsigned DRAIN_CYC    = 6,
    localparam int unsigned CH_W        = ch_width(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CH_W-1:0]  cmd_chan,
    input  logic [VOL_W-1:0] cmd_vol,
    input  logic             cmd_last,
    output logic [N_IN-1:0]  valve_en,
    output logic             pump,
    output logic             out_valve_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned SettleCyc = DEPTH * STAGE_SETTLE;
    localparam int unsigned PhW = phase_width(PULSE_ON, PULSE_OFF, SettleCyc, DRAIN_CYC);

    // Counter reaches zero in the final cycle of a phase, so load length-1.
    localparam logic [PhW-1:0] OnLoad     = PhW'(PULSE_ON - 1);
    localparam logic [PhW-1:0] OffLoad    = PhW'(PULSE_OFF - 1);
    localparam logic [PhW-1:0] SettleLoad = PhW'(SettleCyc - 1);
    localparam logic [PhW-1:0] DrainLoad  = PhW'(DRAIN_CYC - 1);

    state_e           state_q, state_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic             ph_load;
    logic [PhW-1:0]   ph_val;
    logic             ph_zero;
    logic             chan_bad;

    assign chan_bad = (32'(cmd_chan) >= N_IN);

    dwell_counter #(
        .Width (PhW)
    ) u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (ph_val),
        .zero     (ph_zero)
    );

    // Next-state, command latching and phase counter loads.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        vol_d   = vol_q;
        last_d  = last_q;
        err_d   = err_q;
        ph_load = 1'b0;
        ph_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    chan_d = cmd_chan;
                    vol_d  = cmd_vol;
                    last_d = cmd_last;
                    if (chan_bad || (cmd_vol == '0)) begin
                        err_d = err_q | chan_bad;
                        if (cmd_last) begin
                            state_d = StSettle;
                            ph_load = 1'b1;
                            ph_val  = SettleLoad;
                        end
                    end else begin
                        state_d = StOn;
                        ph_load = 1'b1;
                        ph_val  = OnLoad;
                    end
                end
            end
            StOn: begin
                if (ph_zero) begin
                    state_d = StOff;
                    ph_load = 1'b1;
                    ph_val  = OffLoad;
                end
            end
            StOff: begin
                if (ph_zero) begin
                    vol_d = vol_q - VOL_W'(1);
                    if (vol_q != VOL_W'(1)) begin
                        state_d = StOn;
                        ph_load = 1'b1;
                        ph_val  = OnLoad;
                    end else if (last_q) begin
                        state_d = StSettle;
                        ph_load = 1'b1;
                        ph_val  = SettleLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StSettle: begin
                if (ph_zero) begin
                    state_d = StDrain;
                    ph_load = 1'b1;
                    ph_val  = DrainLoad;
                end
            end
            StDrain: begin
                if (ph_zero) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched command registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            chan_q  <= '0;
            vol_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            vol_q   <= vol_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode only registered state, so cmd_* never reaches them combinationally.
    always_comb begin
        valve_en     = '0;
        pump         = 1'b0;
        out_valve_en = 1'b0;
        done         = 1'b0;
        if ((state_q == StOn) || (state_q == StOff)) begin
            valve_en = N_IN'(1) << chan_q;
        end
        if (state_q == StOn) begin
            pump = 1'b1;
        end
        if (state_q == StDrain) begin
            out_valve_en = 1'b1;
        end
        if (state_q == StDone) begin
            done = 1'b1;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign err       = err_q;

endmodule

// File: tb/tb_braid_dispense_seq.sv
// Self-checking bench for braid_dispense_seq: directed table, corner sequences
// and randomized traffic against a timeline model of a dispense round.
module tb_braid_dispense_seq;

    localparam int N      = 16;
    localparam int P_ON   = 2;
    localparam int P      = 4;
    localparam int SETTLE = 32;
    localparam int DRAIN  = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_chan = '0;
    logic [7:0]  cmd_vol = '0;
    logic        cmd_last = 1'b0;
    logic        cmd_ready;
    logic [15:0] valve_en;
    logic        pump, out_valve_en, busy, done, err;

    logic        cmd_valid12 = 1'b0;
    logic [3:0]  cmd_chan12 = '0;
    logic [7:0]  cmd_vol12 = '0;
    logic        cmd_last12 = 1'b0;
    logic        cmd_ready12;
    logic [11:0] valve_en12;
    logic        pump12, out_valve_en12, busy12, done12, err12;

    braid_dispense_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_chan     (cmd_chan),
        .cmd_vol      (cmd_vol),
        .cmd_last     (cmd_last),
        .valve_en     (valve_en),
        .pump         (pump),
        .out_valve_en (out_valve_en),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    braid_dispense_seq #(
        .N_IN (12)
    ) dut12 (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid12),
        .cmd_ready    (cmd_ready12),
        .cmd_chan     (cmd_chan12),
        .cmd_vol      (cmd_vol12),
        .cmd_last     (cmd_last12),
        .valve_en     (valve_en12),
        .pump         (pump12),
        .out_valve_en (out_valve_en12),
        .busy         (busy12),
        .done         (done12),
        .err          (err12)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] obs;
    assign obs = {10'b0, cmd_ready, valve_en, pump, out_valve_en, busy, done, err};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic rdy, input logic [15:0] v, input logic pm,
                                         input logic ov, input logic bz, input logic dn,
                                         input logic er);
        return {10'b0, rdy, v, pm, ov, bz, dn, er};
    endfunction

    // Timeline model: outputs as a function of cycles elapsed since acceptance.
    bit m_act = 1'b0;
    int m_e = 0;
    int m_chan = 0;
    int m_vol = 0;
    bit m_last = 1'b0;
    bit m_err = 1'b0;

    function automatic logic [31:0] model_exp(input int p);
        int k, t1, endk;
        logic [15:0] v;
        k = p - m_e;
        t1 = (m_vol > 0 && m_chan < N) ? m_vol * P : 0;
        endk = m_last ? t1 + SETTLE + DRAIN + 1 : t1;
        if (!m_act || k >= endk) return pack(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, m_err);
        if (k < t1) begin
            v = 16'(1) << m_chan;
            return pack(1'b0, v, (k % P) < P_ON, 1'b0, 1'b1, 1'b0, m_err);
        end
        if (k < t1 + SETTLE) return pack(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, m_err);
        if (k < t1 + SETTLE + DRAIN) return pack(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, m_err);
        return pack(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, m_err);
    endfunction

    task automatic reset_dut();
        cmd_valid = 1'b0;
        cmd_valid12 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 32'(cmd_ready), 32'h1);
    endtask

    typedef struct {
        int          chan;
        int          vol;
        bit          last;
        logic [15:0] valve;
        int          valve_cyc;
        logic [31:0] pump_bits;
        int          drain_cyc;
        int          busy_cyc;
        int          done_at;
        int          done_cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] exp;
        bit prev_ready;
        int p;

        vecs[0] = '{5,  3, 1'b1, 16'h0020, 12, 32'h333,   6, 51, 50, 1};
        vecs[1] = '{2,  0, 1'b1, 16'h0000, 0,  32'h0,     6, 39, 38, 1};
        vecs[2] = '{9,  1, 1'b1, 16'h0200, 4,  32'h3,     6, 43, 42, 1};
        vecs[3] = '{7,  2, 1'b0, 16'h0080, 8,  32'h33,    0, 8,  -1, 0};
        vecs[4] = '{0,  0, 1'b0, 16'h0000, 0,  32'h0,     0, 0,  -1, 0};
        vecs[5] = '{15, 5, 1'b0, 16'h8000, 20, 32'h33333, 0, 20, -1, 0};

        // Reset then idle for 10 cycles.
        reset_dut();
        check("reset_err12", 32'(err12), 32'h0);
        for (int i = 0; i < 10; i++) begin
            check("reset_idle", obs, pack(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            @(negedge clk);
        end

        // Directed command table.
        for (int i = 0; i < 6; i++) begin
            int vcyc, vbad, dcyc, bcyc, done_at, dcnt, ovl;
            logic [31:0] pbits;
            wait_idle();
            cmd_chan = 4'(vecs[i].chan);
            cmd_vol = 8'(vecs[i].vol);
            cmd_last = vecs[i].last;
            cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            vcyc = 0; vbad = 0; dcyc = 0; bcyc = 0; done_at = -1; dcnt = 0; ovl = 0;
            pbits = '0;
            for (int k = 0; k < 70; k++) begin
                if (valve_en != '0) begin
                    vcyc++;
                    if (valve_en !== vecs[i].valve) vbad++;
                    if (out_valve_en) ovl++;
                end
                if (pump && k < 32) pbits[k] = 1'b1;
                if (out_valve_en) dcyc++;
                if (busy) bcyc++;
                if (done) begin
                    dcnt++;
                    if (done_at < 0) done_at = k;
                end
                @(negedge clk);
            end
            check($sformatf("vec%0d_valve_cyc", i), 32'(vcyc), 32'(vecs[i].valve_cyc));
            check($sformatf("vec%0d_valve_val", i), 32'(vbad), 32'h0);
            check($sformatf("vec%0d_pump_bits", i), pbits, vecs[i].pump_bits);
            check($sformatf("vec%0d_drain_cyc", i), 32'(dcyc), 32'(vecs[i].drain_cyc));
            check($sformatf("vec%0d_busy_cyc", i), 32'(bcyc), 32'(vecs[i].busy_cyc));
            check($sformatf("vec%0d_done_at", i), 32'(done_at), 32'(vecs[i].done_at));
            check($sformatf("vec%0d_done_cnt", i), 32'(dcnt), 32'(vecs[i].done_cnt));
            check($sformatf("vec%0d_overlap", i), 32'(ovl), 32'h0);
        end

        // Back-to-back commands with cmd_valid held.
        begin
            int done_i;
            logic [15:0] ev;
            wait_idle();
            cmd_chan = 4'd0; cmd_vol = 8'd1; cmd_last = 1'b0; cmd_valid = 1'b1;
            @(negedge clk);
            cmd_chan = 4'd15; cmd_vol = 8'd2; cmd_last = 1'b1;
            done_i = -1;
            for (int i = 0; i < 60; i++) begin
                if (i <= 12) begin
                    ev = (i < 4) ? 16'h0001 : (i == 4) ? 16'h0000 : 16'h8000;
                    check($sformatf("b2b_valve_%0d", i), 32'(valve_en), 32'(ev));
                end
                if (i == 4) check("b2b_ready_gap", 32'(cmd_ready), 32'h1);
                if (i == 5) cmd_valid = 1'b0;
                if ($countones(valve_en) > 1) check("b2b_onehot", 32'(valve_en), 32'h0);
                if (done && done_i < 0) done_i = i;
                @(negedge clk);
            end
            check("b2b_done_at", 32'(done_i), 32'd51);
        end

        // Reset in the middle of a vol=4 command.
        begin
            int dcnt;
            wait_idle();
            cmd_chan = 4'd3; cmd_vol = 8'd4; cmd_last = 1'b1; cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            repeat (4) @(negedge clk);
            check("abort_pump_before", 32'(pump), 32'h1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("abort_outputs", obs, pack(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            dcnt = 0;
            for (int i = 0; i < 60; i++) begin
                if (done || busy) dcnt++;
                @(negedge clk);
            end
            check("abort_no_done", 32'(dcnt), 32'h0);
            cmd_chan = 4'd1; cmd_vol = 8'd1; cmd_last = 1'b0; cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            check("abort_new_cmd", obs, pack(1'b0, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            wait_idle();
        end

        // Out-of-range channel on the 12-input instance.
        begin
            check("err12_before", 32'(err12), 32'h0);
            cmd_chan12 = 4'd13; cmd_vol12 = 8'd3; cmd_last12 = 1'b0; cmd_valid12 = 1'b1;
            @(negedge clk);
            cmd_valid12 = 1'b0;
            check("err12_ready", 32'(cmd_ready12), 32'h1);
            for (int i = 0; i < 6; i++) begin
                check("err12_sticky", 32'(err12), 32'h1);
                check("err12_valves", {19'b0, valve_en12, pump12}, 32'h0);
                @(negedge clk);
            end
        end

        // Randomized traffic against the timeline model.
        reset_dut();
        m_act = 1'b0;
        m_err = 1'b0;
        prev_ready = 1'b1;
        p = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            p++;
            if (!rst_n) begin
                m_act = 1'b0;
                m_err = 1'b0;
            end else if (prev_ready && cmd_valid) begin
                m_act = 1'b1;
                m_e = p;
                m_chan = int'(cmd_chan);
                m_vol = int'(cmd_vol);
                m_last = cmd_last;
                if (m_chan >= N) m_err = 1'b1;
            end
            exp = model_exp(p);
            prev_ready = exp[21];
            check("random", obs, exp);
            rst_n = ($urandom_range(0, 249) != 0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_chan = 4'($urandom_range(0, 15));
            cmd_vol = 8'($urandom_range(0, 3));
            cmd_last = ($urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
